// File: rtl/sbox_share_arbiter_pkg.sv
// rtl/sbox_share_arbiter_pkg.sv - shared types and constants for the S-box share arbiter
package sbox_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam int ID_W           = 1;
  localparam int PIPE_DEPTH_MIN = 1;
  localparam int PIPE_DEPTH_MAX = 2;

endpackage

// File: rtl/sbox_share_arbiter_sbox_word_unit.sv
// rtl/sbox_share_arbiter_sbox_word_unit.sv - four combinational AES S-box lanes with shared inverse select
module sbox_word_unit (
  input  logic [31:0] data_i,
  input  logic        inv_i,
  output logic [31:0] data_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] t;
    t = gf_mul(x, x);
    r = t;
    for (int i = 0; i < 6; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] a);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8] ^ c[i];
    return b;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] a);
    logic [7:0] d;
    logic [7:0] b;
    d = 8'h05;
    for (int i = 0; i < 8; i++)
      b[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8] ^ d[i];
    return b;
  endfunction

  always_comb begin
    data_o = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (inv_i) data_o[8*i +: 8] = gf_inv(aff_inv(data_i[8*i +: 8]));
      else       data_o[8*i +: 8] = aff_fwd(gf_inv(data_i[8*i +: 8]));
    end
  end

endmodule

// File: rtl/sbox_share_arbiter.sv
// rtl/sbox_share_arbiter.sv - round-robin, burst-locking arbiter sharing one S-box word unit
module sbox_share_arbiter
  import sbox_share_arbiter_pkg::*;
#(
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_data,
  input  logic        r0_inv,
  input  logic        r0_last,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_data,
  input  logic        r1_inv,
  input  logic        r1_last,
  output logic        r0_rsp_valid,
  output logic        r1_rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy
);

  arb_state_e state_q, state_d;
  logic rr_last_q, rr_last_d;
  logic gnt0, gnt1;

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_d   = state_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE: begin
        if (r0_valid && (!r1_valid || rr_last_q)) gnt0 = 1'b1;
        else if (r1_valid)                        gnt1 = 1'b1;
      end
      LOCK0:   gnt0 = r0_valid;
      LOCK1:   gnt1 = r1_valid;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0) begin
      if (r0_last) begin
        state_d   = IDLE;
        rr_last_d = 1'b0;
      end else begin
        state_d = LOCK0;
      end
    end else if (gnt1) begin
      if (r1_last) begin
        state_d   = IDLE;
        rr_last_d = 1'b1;
      end else begin
        state_d = LOCK1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  logic            acc_valid, acc_inv;
  logic [31:0]     acc_data;
  logic [ID_W-1:0] acc_id;

  assign acc_valid = gnt0 | gnt1;
  assign acc_data  = gnt1 ? r1_data : r0_data;
  assign acc_inv   = gnt1 ? r1_inv  : r0_inv;
  assign acc_id    = gnt1;

  logic            u_valid, u_inv, s0_busy;
  logic [31:0]     u_data, u_sub;
  logic [ID_W-1:0] u_id;

  if (PIPE_DEPTH == PIPE_DEPTH_MIN) begin : g_p1
    assign u_valid = acc_valid;
    assign u_data  = acc_data;
    assign u_inv   = acc_inv;
    assign u_id    = acc_id;
    assign s0_busy = 1'b0;
  end else begin : g_p2
    logic            s0_valid_q, s0_inv_q;
    logic [31:0]     s0_data_q;
    logic [ID_W-1:0] s0_id_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s0_valid_q <= 1'b0;
        s0_inv_q   <= 1'b0;
        s0_data_q  <= 32'h0;
        s0_id_q    <= '0;
      end else begin
        s0_valid_q <= acc_valid;
        if (acc_valid) begin
          s0_inv_q  <= acc_inv;
          s0_data_q <= acc_data;
          s0_id_q   <= acc_id;
        end
      end
    end

    assign u_valid = s0_valid_q;
    assign u_data  = s0_data_q;
    assign u_inv   = s0_inv_q;
    assign u_id    = s0_id_q;
    assign s0_busy = s0_valid_q;
  end

  sbox_word_unit u_sbox (
    .data_i (u_data),
    .inv_i  (u_inv),
    .data_o (u_sub)
  );

  logic        rsp0_q, rsp1_q;
  logic [31:0] rsp_data_q;

  // rsp_data holds the last substituted word between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rsp_data_q <= 32'h0;
    end else begin
      rsp0_q <= u_valid && (u_id == 1'b0);
      rsp1_q <= u_valid && (u_id == 1'b1);
      if (u_valid) rsp_data_q <= u_sub;
    end
  end

  assign r0_rsp_valid = rsp0_q;
  assign r1_rsp_valid = rsp1_q;
  assign rsp_data     = rsp_data_q;
  assign busy         = (state_q != IDLE) || s0_busy || rsp0_q || rsp1_q;

endmodule
